hamming_byte_assembler: RTL and testbench

Downstream of the Hamming (7,4) decoder. Consumes a stream of corrected 7-bit codewords, extracts the 4 data bits from each, and packs consecutive nibbles into bytes, high nibble first. Bytes leave through a single-entry valid/ready output register toward the TinyTapeout output pins or a host interface. The block also keeps a byte counter and rechecks each codeword's syndrome as an integrity check.

---
 rtl/hamming_byte_assembler.sv | 96 +++++++++
 tb/tb_hamming_byte_assembler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_byte_assembler.sv
// Packs the data nibbles of corrected Hamming (7,4) codewords into bytes, high nibble first,
// behind a single-entry valid/ready output register, with byte and integrity-error counters.
module hamming_byte_assembler #(
   parameter int CNT_W = 8,
   parameter int ERR_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       code_in,
   input  logic             code_valid,
   output logic             code_ready,
   input  logic             align,
   output logic [7:0]       byte_data,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic [CNT_W-1:0] byte_count,
   output logic [ERR_W-1:0] chk_err_count
);

   typedef enum logic [0:0] {EXP_HIGH = 1'b0, EXP_LOW = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
   localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

   // Syndrome bits {s2,s1,s0}; bit 6 of the word is Hamming position 1
   function automatic logic [2:0] syndrome(input logic [6:0] c);
      syndrome = {c[3] ^ c[2] ^ c[1] ^ c[0],
                  c[5] ^ c[4] ^ c[1] ^ c[0],
                  c[6] ^ c[4] ^ c[2] ^ c[0]};
   endfunction

   state_t     state_r;
   state_t     state_nx_s;
   logic [3:0] hold_nib_r;
   logic [3:0] nib_s;
   logic [2:0] syn_s;
   logic       accept_s;
   logic       load_s;

   // Input handshake, nibble extraction and next-state decode
   always_comb begin
      nib_s      = {code_in[4], code_in[2], code_in[1], code_in[0]};
      syn_s      = syndrome(code_in);
      // a high nibble never touches the output register, so it may enter even while stalled
      code_ready = rst_n & ~align & ((state_r == EXP_HIGH) | ~byte_valid | byte_ready);
      accept_s   = code_valid & code_ready;
      load_s     = 1'b0;
      state_nx_s = state_r;
      if (align) begin
         state_nx_s = EXP_HIGH;
      end else if (accept_s) begin
         case (state_r)
            EXP_HIGH: state_nx_s = EXP_LOW;
            EXP_LOW: begin
               state_nx_s = EXP_HIGH;
               load_s     = 1'b1;
            end
            default: state_nx_s = EXP_HIGH;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // State, held nibble, output register and counters
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= EXP_HIGH;
         hold_nib_r    <= 4'h0;
         byte_data     <= 8'h00;
         byte_valid    <= 1'b0;
         byte_count    <= '0;
         chk_err_count <= '0;
      end else begin
         state_r <= state_nx_s;
         if (align) begin
            hold_nib_r <= 4'h0;
         end else if (accept_s && (state_r == EXP_HIGH)) begin
            hold_nib_r <= nib_s;
         end
         // a load in the same cycle as a transfer keeps valid high with the new byte
         if (load_s) begin
            byte_data  <= {hold_nib_r, nib_s};
            byte_valid <= 1'b1;
            byte_count <= byte_count + CNT_ONE;
         end else if (byte_ready) begin
            byte_valid <= 1'b0;
         end
         if (accept_s && (syn_s != 3'b000) && (chk_err_count != ERR_MAX)) begin
            chk_err_count <= chk_err_count + ERR_ONE;
         end
      end
   end

endmodule

// File: tb/tb_hamming_byte_assembler.sv
// Directed bench for hamming_byte_assembler: a reference model pushes expected bytes into a
// queue as codewords are accepted; a negedge monitor pops and compares on each byte transfer.
module tb_hamming_byte_assembler;
   localparam int CNT_W = 8;
   localparam int ERR_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [6:0]       code_in = 7'h00;
   logic             code_valid = 1'b0;
   logic             code_ready;
   logic             align = 1'b0;
   logic [7:0]       byte_data;
   logic             byte_valid;
   logic             byte_ready = 1'b0;
   logic [CNT_W-1:0] byte_count;
   logic [ERR_W-1:0] chk_err_count;

   int         tests_run = 0;
   int         tests_failed = 0;
   logic [7:0] exp_q[$];
   bit         exp_low = 1'b0;
   logic [3:0] exp_hold = 4'h0;
   int         exp_count = 0;
   int         exp_err = 0;
   int         popped = 0;
   int         stalls = 0;

   hamming_byte_assembler #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
      .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid),
      .code_ready(code_ready), .align(align), .byte_data(byte_data),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_count(byte_count),
      .chk_err_count(chk_err_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Standard Hamming (7,4) encoder: word = {p1,p2,d3,p4,d5,d6,d7}
   function automatic logic [6:0] encode(input logic [3:0] d);
      logic p1, p2, p4;
      p1 = d[3] ^ d[2] ^ d[0];
      p2 = d[3] ^ d[1] ^ d[0];
      p4 = d[2] ^ d[1] ^ d[0];
      return {p1, p2, d[3], p4, d[2], d[1], d[0]};
   endfunction

   // Scoreboard monitor: a byte is transferred at the next edge when valid & ready here
   always @(negedge clk) begin
      if (rst_n && byte_valid === 1'b1 && byte_ready) begin
         if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $error("FAIL unexpected_byte: observed 0x%0h expected none", byte_data);
         end else begin
            check("byte_out", {24'h0, byte_data}, {24'h0, exp_q.pop_front()});
            popped++;
         end
      end
   end

   task automatic send(input logic [6:0] cw);
      int n;
      logic [3:0] nib;
      n = 0;
      code_in = cw;
      code_valid = 1'b1;
      @(negedge clk);
      while (!code_ready && n < 20) begin
         n++;
         stalls++;
         @(negedge clk);
      end
      if (!code_ready) begin
         tests_run++;
         tests_failed++;
         $error("FAIL send_timeout: observed code_ready=0 expected 1 within 20 cycles");
      end
      @(posedge clk);
      #1;
      nib = {cw[4], cw[2], cw[1], cw[0]};
      if (!exp_low) begin
         exp_hold = nib;
         exp_low = 1'b1;
      end else begin
         exp_q.push_back({exp_hold, nib});
         exp_count = (exp_count + 1) % (1 << CNT_W);
         exp_low = 1'b0;
      end
      if (cw !== encode(nib) && exp_err < (1 << ERR_W) - 1) exp_err++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [6:0] cw;
      logic [6:0] flip;
      int pop0;

      // reset and idle
      rst_n = 1'b0;
      byte_ready = 1'b1;
      @(negedge clk);
      check("rst_code_ready", {31'h0, code_ready}, 32'h0);
      tick(2);
      check("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
      check("rst_byte_count", {24'h0, byte_count}, 32'h0);
      check("rst_err_count", {28'h0, chk_err_count}, 32'h0);
      check("rst_code_ready2", {31'h0, code_ready}, 32'h0);
      rst_n = 1'b1;
      #1;
      check("idle_code_ready", {31'h0, code_ready}, 32'h1);

      // basic pack
      send(encode(4'hA));
      code_valid = 1'b0;
      check("basic_no_early_valid", {31'h0, byte_valid}, 32'h0);
      send(encode(4'h5));
      code_valid = 1'b0;
      check("basic_valid", {31'h0, byte_valid}, 32'h1);
      check("basic_data", {24'h0, byte_data}, 32'hA5);
      check("basic_count", {24'h0, byte_count}, 32'h1);
      check("basic_err", {28'h0, chk_err_count}, 32'h0);
      tick(2);

      // backpressure
      byte_ready = 1'b0;
      stalls = 0;
      send(encode(4'h1));
      send(encode(4'h2));
      send(encode(4'h3));
      check("bp_high_no_stall", stalls, 32'h0);
      code_in = encode(4'h4);
      code_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("bp_low_stalled", {31'h0, code_ready}, 32'h0);
      check("bp_hold_valid", {31'h0, byte_valid}, 32'h1);
      check("bp_hold_data", {24'h0, byte_data}, 32'h12);
      @(posedge clk);
      #1;
      byte_ready = 1'b1;
      send(encode(4'h4));
      send(encode(4'h5));
      send(encode(4'h6));
      code_valid = 1'b0;
      tick(4);
      check("bp_count", {24'h0, byte_count}, exp_count);
      check("bp_drained", exp_q.size(), 32'h0);

      // full throughput
      stalls = 0;
      pop0 = popped;
      for (int i = 0; i < 16; i++) begin
         cw = encode(4'(i) ^ 4'h9);
         send(cw);
      end
      code_valid = 1'b0;
      tick(3);
      check("tp_no_stalls", stalls, 32'h0);
      check("tp_bytes", popped - pop0, 32'd8);
      check("tp_count", {24'h0, byte_count}, exp_count);

      // align mid-byte
      send(encode(4'h3));
      code_in = encode(4'h9);
      code_valid = 1'b1;
      align = 1'b1;
      #1;
      check("align_blocks", {31'h0, code_ready}, 32'h0);
      @(posedge clk);
      #1;
      align = 1'b0;
      code_valid = 1'b0;
      exp_low = 1'b0;
      send(encode(4'hC));
      send(encode(4'h7));
      code_valid = 1'b0;
      check("align_data", {24'h0, byte_data}, 32'hC7);
      check("align_count", {24'h0, byte_count}, exp_count);
      tick(2);

      // integrity and saturation
      for (int i = 0; i < 20; i++) begin
         flip = 7'b0000001 << (i % 7);
         cw = encode(4'((i * 7) % 16)) ^ flip;
         send(cw);
      end
      code_valid = 1'b0;
      tick(3);
      check("err_saturated", {28'h0, chk_err_count}, 32'd15);
      check("err_model", {28'h0, chk_err_count}, exp_err);
      check("err_count", {24'h0, byte_count}, exp_count);

      // reset mid-byte with a pending output
      byte_ready = 1'b0;
      send(encode(4'hE));
      send(encode(4'h1));
      send(encode(4'hF));
      code_valid = 1'b0;
      check("mid_pending", {31'h0, byte_valid}, 32'h1);
      rst_n = 1'b0;
      tick(1);
      check("mid_rst_valid", {31'h0, byte_valid}, 32'h0);
      check("mid_rst_data", {24'h0, byte_data}, 32'h0);
      check("mid_rst_count", {24'h0, byte_count}, 32'h0);
      check("mid_rst_err", {28'h0, chk_err_count}, 32'h0);
      check("mid_rst_ready", {31'h0, code_ready}, 32'h0);
      exp_q.delete();
      exp_low = 1'b0;
      exp_count = 0;
      exp_err = 0;
      rst_n = 1'b1;
      byte_ready = 1'b1;
      send(encode(4'h6));
      send(encode(4'hD));
      code_valid = 1'b0;
      check("post_rst_data", {24'h0, byte_data}, 32'h6D);
      check("post_rst_count", {24'h0, byte_count}, 32'h1);
      tick(2);
      check("final_drained", exp_q.size(), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end
endmodule
